// File: rtl/p_msg_src.sv
// p_msg_src: sequences Poly1305 key r, key s and zero-padded 16-byte message
// blocks into a tag engine that pulls data with request edges.
module p_msg_src (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [31:0]  i_len_msg,
  input  logic [127:0] i_key_r,
  input  logic [127:0] i_key_s,
  input  logic         i_wvalid,
  input  logic [31:0]  i_wdata,
  output logic         o_wready,
  input  logic         i_rqst_msg,
  output logic         o_start,
  output logic         o_en_msg,
  output logic [127:0] o_msg,
  output logic [31:0]  o_len_msg,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [2:0] {IDLE, KEYS, FILL, HOLD, FIN} state_t;
  state_t state, state_nxt;

  logic         rqst_q, pend;
  logic [127:0] key_s_q, blk;
  logic [31:0]  rem;
  logic [28:0]  blk_left;
  logic [2:0]   wcnt, words_need;
  logic [32:0]  len_p15;
  logic         rqst_edge, last_blk, accept, blk_done, send;

  // Zero every byte of word k whose message index falls at or past rem5.
  function automatic logic [31:0] mask_word(input logic [31:0] w,
                                            input logic [1:0]  k,
                                            input logic [4:0]  rem5,
                                            input logic        last);
    logic [31:0] m;
    logic [4:0]  idx;
    m = w;
    for (int j = 0; j < 4; j++) begin
      idx = {1'b0, k, 2'(j)};
      if (last && (idx >= rem5)) m[8*j +: 8] = 8'h00;
    end
    return m;
  endfunction

  assign rqst_edge  = i_rqst_msg & ~rqst_q;
  assign last_blk   = (blk_left == 29'd1);
  // rem is 1..16 in the last block, so ceil(rem/4) fits in three bits.
  assign words_need = last_blk ? (rem[4:2] + {2'b00, |rem[1:0]}) : 3'd4;
  assign accept     = (state == FILL) & i_wvalid;
  assign blk_done   = accept & ((wcnt + 3'd1) == words_need);
  assign send       = (state == HOLD) & (pend | rqst_edge);
  assign len_p15    = {1'b0, i_len_msg} + 33'd15;

  always_comb begin
    state_nxt = state;
    o_wready  = 1'b0;
    case (state)
      IDLE: if (i_start) state_nxt = KEYS;
      KEYS: if (rqst_edge) state_nxt = (blk_left == 29'd0) ? FIN : FILL;
      FILL: begin
        o_wready = 1'b1;
        if (blk_done) state_nxt = HOLD;
      end
      HOLD: if (send) state_nxt = last_blk ? FIN : FILL;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rqst_q    <= 1'b0;
      pend      <= 1'b0;
      o_start   <= 1'b0;
      o_en_msg  <= 1'b0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
      o_msg     <= '0;
      o_len_msg <= '0;
    end else begin
      state    <= state_nxt;
      rqst_q   <= i_rqst_msg;
      o_start  <= 1'b0;
      o_en_msg <= 1'b0;
      o_done   <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          o_start   <= 1'b1;
          o_busy    <= 1'b1;
          o_msg     <= i_key_r;
          o_len_msg <= i_len_msg;
          pend      <= 1'b0;
        end
        KEYS: if (rqst_edge) begin
          o_en_msg <= 1'b1;
          o_msg    <= key_s_q;
        end
        FILL: if (rqst_edge) pend <= 1'b1;
        HOLD: if (send) begin
          o_en_msg <= 1'b1;
          o_msg    <= blk;
          pend     <= 1'b0;
        end
        FIN: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Job datapath: reloaded on every accepted start, so it needs no reset.
  always_ff @(posedge i_clk) begin
    case (state)
      IDLE: if (i_start) begin
        key_s_q  <= i_key_s;
        rem      <= i_len_msg;
        blk_left <= len_p15[32:4];
        blk      <= '0;
        wcnt     <= 3'd0;
      end
      FILL: if (accept) begin
        blk[{wcnt[1:0], 5'd0} +: 32] <= mask_word(i_wdata, wcnt[1:0], rem[4:0], last_blk);
        wcnt <= wcnt + 3'd1;
      end
      HOLD: if (send) begin
        blk      <= '0;
        wcnt     <= 3'd0;
        rem      <= rem - 32'd16;
        blk_left <= blk_left - 29'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/p_msg_src.md
P_MSG_SRC -- requirements
Module: p_msg_src

Interface
REQ-001 Ports SHALL be, clock and reset first:
- i_clk  in  1  sole clock; all logic rising-edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begins one tag job.
- i_len_msg  in  32  message length in bytes; sampled on i_start.
- i_key_r  in  128  Poly1305 key r; sampled on i_start.
- i_key_s  in  128  Poly1305 key s; sampled on i_start.
- i_wvalid  in  1  message word valid.
- i_wdata  in  32  message word; first byte in [7:0].
- o_wready  out  1  word accepted when i_wvalid & o_wready.
- i_rqst_msg  in  1  block request level from the tag engine.
- o_start  out  1  one-cycle start pulse to the tag engine.
- o_en_msg  out  1  one-cycle block-valid strobe.
- o_msg  out  128  key or message block.
- o_len_msg  out  32  latched length, held for the whole job.
- o_busy  out  1  job in progress.
- o_done  out  1  one-cycle job-complete pulse.

Function
REQ-002 The block SHALL supply the tag engine's request/enable protocol: key r at start, then key s, then ceil(len/16) message blocks.
REQ-003 States SHALL be IDLE, KEYS, FILL, HOLD and FIN.
REQ-004 In IDLE, i_start SHALL latch the keys and length, load o_msg<=i_key_r and o_len_msg<=i_len_msg, set o_busy, and go to KEYS. o_start SHALL pulse the next cycle.
REQ-005 A request SHALL be the rising edge of i_rqst_msg (current 1, previous-cycle 0). Levels without an edge SHALL NOT count.
REQ-006 In KEYS, on a request edge at cycle n: o_msg<=key s and o_en_msg=1 at cycle n+1. Then go to FILL, or to FIN if the length is 0.
REQ-007 FILL SHALL assert o_wready and accept words little-endian into the block: word k goes to bits [32k+31:32k].
REQ-008 FILL SHALL accept exactly 4 words per full block. For the last block it SHALL accept ceil(rem/4) words, where rem = len - 16*(blocks sent), 1..16.
REQ-009 In the last block, bytes at index >= rem SHALL be forced to 0, including the unused upper bytes of a partial last word. Words not accepted SHALL be zero.
REQ-010 When the block is complete, FILL SHALL go to HOLD with o_wready=0.
REQ-011 A request edge arriving in FILL SHALL be recorded as pending, one deep.
REQ-012 In HOLD, with a pending or current request edge, o_msg<=block and o_en_msg=1 for one cycle, and the pending flag clears.
- If more blocks remain: next state FILL.
- Otherwise: next state FIN.
REQ-013 FIN SHALL pulse o_done for one cycle, clear o_busy, and return to IDLE. o_msg and o_len_msg SHALL hold their values.
REQ-014 i_start while o_busy SHALL be ignored.
REQ-015 A request edge in IDLE or FIN SHALL be ignored. A second edge while a request is already pending SHALL be ignored.
REQ-016 The block count SHALL be computed as (len+15)>>4 in 33 bits, with no overflow at len=0xFFFFFFFF.
REQ-017 o_wready SHALL be 0 outside FILL. i_wvalid outside FILL SHALL have no effect.

Reset
REQ-018 While i_rst=1 at a clock edge: state=IDLE; pending and request-edge history=0.
REQ-019 On that reset, o_start=o_en_msg=o_done=o_busy=o_wready=0 and o_msg=0, o_len_msg=0.
REQ-020 Reset mid-job SHALL abandon the job. No o_done SHALL be produced, and the next i_start SHALL behave as a fresh job.

Verification
REQ-021 Bench SHALL cover the RFC 8439 vector:
- Stimulus: len=34, r=a806d542_fe52447f_336d5557_78bed685, s=1bf54941_aff6bf4a_fdb20dfb_8a800301. Words 70797243,72676f74,69687061,6f462063,206d7572,65736552,68637261,6f724720,aabb7075.
- Required response: o_msg=r after start, one o_start pulse, then strobes s, 6f462063_69687061_72676f74_70797243, 6f724720_68637261_65736552_206d7572, 00000000_00000000_00000000_00007075, then o_done. Exactly 9 words accepted.
REQ-022 Bench SHALL cover len=0: exactly one o_en_msg (key s), then o_done; o_wready never asserted.
REQ-023 Bench SHALL cover len=16 with a request edge before any word arrives: the strobe follows the 4th word by exactly 2 cycles, and o_done follows.
REQ-024 Bench SHALL cover i_rqst_msg held high for 5 cycles: one edge yields exactly one o_en_msg.
REQ-025 Bench SHALL cover i_rst asserted in FILL after 2 words: all outputs 0 the next cycle, and no o_done. A following len=34 job SHALL reproduce REQ-021 exactly.
REQ-026 Bench SHALL cover i_start pulsed during a busy job: no change to the latched length or keys, and no extra o_start.
